// File: rtl/mis_pkg.sv
// Shared constants and FSM encoding for the minimum-mismatch element selector.
package mis_pkg;

  localparam int N_ELEM = 18;
  localparam int SFM_W  = 7;
  localparam int CODE_W = 5;

  // Requests above this many elements saturate to the full array.
  localparam logic [CODE_W-1:0] CODE_CLAMP = CODE_W'(N_ELEM);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEL  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mis_argmax18.sv
// Combinational argmax over unmasked elements; a binary comparator tree
// where the lower-index side wins on equal values.
module mis_argmax18
  import mis_pkg::*;
#(
  parameter int N = N_ELEM,
  parameter int W = SFM_W
) (
  input  logic [N*W-1:0] values,
  input  logic [N-1:0]   mask,
  output logic [4:0]     index,
  output logic [N-1:0]   onehot,
  output logic           found
);

  localparam int LEAVES = 1 << $clog2(N);

  logic [W-1:0] node_val [1:2*LEAVES-1];
  logic [4:0]   node_idx [1:2*LEAVES-1];
  logic         node_ok  [1:2*LEAVES-1];

  always_comb begin
    for (int k = 1; k < 2*LEAVES; k++) begin
      node_val[k] = '0;
      node_idx[k] = '0;
      node_ok[k]  = 1'b0;
    end
    for (int i = 0; i < N; i++) begin
      node_val[LEAVES+i] = values[W*i +: W];
      node_idx[LEAVES+i] = 5'(i);
      node_ok[LEAVES+i]  = !mask[i];
    end
    // Right child holds higher indices, so it only wins on a strict greater-than.
    for (int k = LEAVES - 1; k >= 1; k--) begin
      if (node_ok[2*k+1] && (!node_ok[2*k] || node_val[2*k+1] > node_val[2*k])) begin
        node_val[k] = node_val[2*k+1];
        node_idx[k] = node_idx[2*k+1];
        node_ok[k]  = 1'b1;
      end else begin
        node_val[k] = node_val[2*k];
        node_idx[k] = node_idx[2*k];
        node_ok[k]  = node_ok[2*k];
      end
    end
    index = node_idx[1];
    found = node_ok[1];
    onehot = '0;
    for (int i = 0; i < N; i++) begin
      onehot[i] = found && (index == 5'(i));
    end
  end

endmodule

// File: rtl/mis_vq18_selector.sv
// Picks `code` unit DAC elements, one per cycle, in descending shaping-filter
// order, then publishes the selection vector with a one-cycle valid pulse.
module mis_vq18_selector #(
  parameter int N_ELEM = mis_pkg::N_ELEM,
  parameter int SFM_W  = mis_pkg::SFM_W
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4:0]              code,
  input  logic [N_ELEM*SFM_W-1:0] sfm,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [N_ELEM-1:0]       sv,
  output logic                    out_valid,
  output logic                    code_sat
);

  import mis_pkg::*;

  localparam logic [4:0] LIMIT = 5'(N_ELEM);

  state_t                    state, state_next;
  logic [N_ELEM*SFM_W-1:0]   sfm_q, sfm_next;
  logic [N_ELEM-1:0]         mask, mask_next, sv_next, win_onehot;
  logic [4:0]                remaining, rem_next, code_clamped, unused_win_index;
  logic                      sat_next, win_found;

  assign code_clamped = (code > LIMIT) ? LIMIT : code;
  assign in_ready     = (state == IDLE);

  mis_argmax18 #(
    .N (N_ELEM),
    .W (SFM_W)
  ) u_argmax (
    .values (sfm_q),
    .mask   (mask),
    .index  (unused_win_index),
    .onehot (win_onehot),
    .found  (win_found)
  );

  always_comb begin
    state_next = state;
    sfm_next   = sfm_q;
    mask_next  = mask;
    rem_next   = remaining;
    sat_next   = code_sat;
    case (state)
      IDLE: begin
        if (in_valid) begin
          sfm_next   = sfm;
          mask_next  = '0;
          rem_next   = code_clamped;
          sat_next   = (code > LIMIT);
          state_next = (code_clamped == 5'd0) ? DONE : SEL;
        end
      end
      SEL: begin
        if (win_found) begin
          mask_next = mask | win_onehot;
        end
        rem_next = (remaining == 5'd0) ? 5'd0 : remaining - 5'd1;
        if (remaining <= 5'd1) begin
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
    // sv captures the mask as it will be after this edge, including the final pick.
    sv_next = (state_next == DONE) ? mask_next : sv;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sfm_q     <= '0;
      mask      <= '0;
      remaining <= '0;
      sv        <= '0;
      out_valid <= 1'b0;
      code_sat  <= 1'b0;
    end else begin
      state     <= state_next;
      sfm_q     <= sfm_next;
      mask      <= mask_next;
      remaining <= rem_next;
      sv        <= sv_next;
      out_valid <= (state_next == DONE);
      code_sat  <= sat_next;
    end
  end

endmodule

// File: tb/tb_mis_vq18_selector.sv
// Scoreboard bench for mis_vq18_selector: directed samples push expected
// results; an independent monitor checks every out_valid pulse.
module tb_mis_vq18_selector;

  localparam int N = 18;
  localparam int W = 7;

  logic           clk = 1'b0;
  logic           rst;
  logic [4:0]     code;
  logic [N*W-1:0] sfm;
  logic           in_valid;
  logic           in_ready;
  logic [N-1:0]   sv;
  logic           out_valid;
  logic           code_sat;

  mis_vq18_selector dut (
    .clk       (clk),
    .rst       (rst),
    .code      (code),
    .sfm       (sfm),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sv        (sv),
    .out_valid (out_valid),
    .code_sat  (code_sat)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int acc_count = 0;
  int last_acc = 0;
  int prev_acc = 0;
  int txn = 0;
  logic prev_ov = 1'b0;

  logic [N-1:0] exp_sv_q  [$];
  logic         exp_sat_q [$];
  int           exp_lat_q [$];
  int           acc_q     [$];

  logic [N-1:0] e_sv;
  logic         e_sat;
  int           e_lat;
  int           a_edge;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
  endtask

  always @(posedge clk) cyc++;

  // Accepts are spotted just after the falling edge, before the edge that takes them.
  always @(negedge clk) begin
    #1;
    if (rst) acc_q.delete();
    else if (in_valid && in_ready) begin
      acc_q.push_back(cyc + 1);
      prev_acc = last_acc;
      last_acc = cyc + 1;
      acc_count++;
    end
  end

  always @(posedge clk) begin
    #1;
    if (out_valid) begin
      checkOutput("pulse_width", {31'd0, prev_ov}, 32'd0);
      if (exp_sv_q.size() == 0 || acc_q.size() == 0) begin
        checks++;
        $display("[TB] FAIL unexpected_out_valid: got sv=0x%0h, expected no pulse", sv);
      end else begin
        e_sv   = exp_sv_q.pop_front();
        e_sat  = exp_sat_q.pop_front();
        e_lat  = exp_lat_q.pop_front();
        a_edge = acc_q.pop_front();
        checkOutput($sformatf("sv[%0d]", txn), 32'(sv), 32'(e_sv));
        checkOutput($sformatf("code_sat[%0d]", txn), {31'd0, code_sat}, {31'd0, e_sat});
        checkOutput($sformatf("latency[%0d]", txn), 32'(cyc - a_edge + 1), 32'(e_lat));
        txn++;
      end
    end
    prev_ov = out_valid;
  end

  task automatic applyStimulus(input logic [4:0] c, input logic [N*W-1:0] s, input bit push,
                               input logic [N-1:0] esv, input bit esat, input bit hold);
    int waited = 0;
    @(negedge clk);
    while (!in_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      checks++;
      $display("[TB] FAIL ready_timeout: got in_ready=0, expected 1");
      return;
    end
    if (push) begin
      exp_sv_q.push_back(esv);
      exp_sat_q.push_back(esat);
      exp_lat_q.push_back(((c > 5'd18) ? 18 : int'(c)) + 1);
    end
    code = c;
    sfm = s;
    in_valid = 1'b1;
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int w = 0;
    while (exp_sv_q.size() != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    if (exp_sv_q.size() != 0) begin
      checks++;
      $display("[TB] FAIL drain_timeout: got %0d pending results, expected 0", exp_sv_q.size());
    end
    repeat (2) @(negedge clk);
  endtask

  function automatic logic [N*W-1:0] ramp();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = 7'(i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] reverse_ramp();
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = 7'(N - 1 - i);
    return v;
  endfunction

  function automatic logic [N*W-1:0] flat(input logic [6:0] x);
    logic [N*W-1:0] v;
    for (int i = 0; i < N; i++) v[W*i +: W] = x;
    return v;
  endfunction

  logic [N*W-1:0] pat;
  int base;
  int w;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    code = '0;
    sfm = '0;
    repeat (3) @(negedge clk);
    checkOutput("reset_sv", 32'(sv), 32'd0);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_code_sat", {31'd0, code_sat}, 32'd0);
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    rst = 1'b0;

    applyStimulus(5'd0, ramp(), 1, 18'h00000, 0, 0);
    applyStimulus(5'd3, ramp(), 1, 18'h38000, 0, 0);
    applyStimulus(5'd2, flat(7'd5), 1, 18'h00003, 0, 0);

    pat = '0;
    for (int i = 0; i < N; i++) pat[W*i +: W] = 7'($urandom_range(0, 127));
    applyStimulus(5'd25, pat, 1, 18'h3FFFF, 1, 0);
    applyStimulus(5'd18, flat(7'h7F), 1, 18'h3FFFF, 0, 0);

    pat = flat(7'd1);
    pat[W*3 +: W] = 7'h7F;
    pat[W*9 +: W] = 7'h7F;
    applyStimulus(5'd1, pat, 1, 18'h00008, 0, 0);

    pat = flat(7'd0);
    pat[W*5 +: W]  = 7'h40;
    pat[W*12 +: W] = 7'h3F;
    applyStimulus(5'd2, pat, 1, 18'h01020, 0, 0);

    pat = flat(7'd0);
    pat[W*7 +: W] = 7'd100;
    applyStimulus(5'd3, pat, 1, 18'h00083, 0, 0);
    waitDrain();

    // Hold in_valid through SEL while the bus changes to a reversed ramp.
    applyStimulus(5'd10, ramp(), 1, 18'h3FF00, 0, 1);
    base = acc_count;
    sfm = reverse_ramp();
    code = 5'd1;
    exp_sv_q.push_back(18'h00001);
    exp_sat_q.push_back(1'b0);
    exp_lat_q.push_back(2);
    w = 0;
    while (acc_count < base + 1 && w < 40) begin
      @(negedge clk);
      w++;
    end
    checkOutput("accept_gap", 32'(last_acc - prev_acc), 32'd12);
    in_valid = 1'b0;
    waitDrain();

    applyStimulus(5'd19, flat(7'd9), 1, 18'h3FFFF, 1, 0);
    waitDrain();

    // Abort a code=8 selection with reset during its fourth SEL cycle.
    applyStimulus(5'd8, ramp(), 0, 18'h0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort_sv", 32'(sv), 32'd0);
    checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("abort_code_sat", {31'd0, code_sat}, 32'd0);
    checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    checkOutput("abort_sv_hold", 32'(sv), 32'd0);

    applyStimulus(5'd4, ramp(), 1, 18'h3C000, 0, 0);
    waitDrain();
    checkOutput("sv_hold", 32'(sv), 32'h3C000);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
